// File: rtl/vec_dot_feeder.sv
// Packs a stream of lhs/rhs float element pairs into fixed-width vector pairs for vec_dot.
// Two ping-pong buffers let one vector fill while the previous one waits for the consumer.
module vec_dot_feeder #(
    parameter int EXP_WIDTH = 8,
    parameter int MAN_WIDTH = 23,
    parameter int BIAS      = -127,
    parameter int VEC_SIZE  = 17,
    localparam int FLOAT_WIDTH = 1 + EXP_WIDTH + MAN_WIDTH,
    localparam int VEC_WIDTH   = VEC_SIZE * FLOAT_WIDTH,
    localparam int CW          = $clog2(VEC_SIZE + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [FLOAT_WIDTH-1:0] in_lhs,
    input  logic [FLOAT_WIDTH-1:0] in_rhs,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [VEC_WIDTH-1:0]   out_lhs,
    output logic [VEC_WIDTH-1:0]   out_rhs,
    output logic [CW-1:0]          out_count
);

    localparam int LW = (VEC_SIZE > 1) ? $clog2(VEC_SIZE) : 1;

    logic [VEC_WIDTH-1:0] buf_lhs   [2];
    logic [VEC_WIDTH-1:0] buf_rhs   [2];
    logic [CW-1:0]        buf_count [2];

    logic          wr_sel;
    logic          rd_sel;
    logic [1:0]    full_count;
    logic [LW-1:0] lane;

    logic accept;
    logic last_lane;
    logic complete;
    logic out_take;

    // Handshake flags depend only on registered state, so out_ready never reaches in_ready.
    assign in_ready  = (full_count < 2'd2);
    assign out_valid = (full_count != 2'd0);
    assign out_lhs   = buf_lhs[rd_sel];
    assign out_rhs   = buf_rhs[rd_sel];
    assign out_count = buf_count[rd_sel];

    assign accept    = in_valid & in_ready;
    assign last_lane = (lane == LW'(VEC_SIZE - 1));
    assign complete  = accept & (last_lane | in_last);
    assign out_take  = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                buf_lhs[b]   <= '0;
                buf_rhs[b]   <= '0;
                buf_count[b] <= '0;
            end
            wr_sel     <= 1'b0;
            rd_sel     <= 1'b0;
            full_count <= 2'd0;
            lane       <= '0;
        end else begin
            // A consumed buffer is zeroed right away so it is clean when filling restarts in it.
            // It can never be the buffer being written this cycle: take needs full>0, write needs full<2.
            if (out_take) begin
                buf_lhs[rd_sel]   <= '0;
                buf_rhs[rd_sel]   <= '0;
                buf_count[rd_sel] <= '0;
                rd_sel            <= ~rd_sel;
            end

            if (accept) begin
                for (int i = 0; i < VEC_SIZE; i++) begin
                    if (lane == LW'(i)) begin
                        buf_lhs[wr_sel][i*FLOAT_WIDTH +: FLOAT_WIDTH] <= in_lhs;
                        buf_rhs[wr_sel][i*FLOAT_WIDTH +: FLOAT_WIDTH] <= in_rhs;
                    end
                end
                if (complete) begin
                    buf_count[wr_sel] <= CW'(lane) + CW'(1);
                    lane              <= '0;
                    wr_sel            <= ~wr_sel;
                end else begin
                    lane <= lane + LW'(1);
                end
            end

            case ({complete, out_take})
                2'b10:   full_count <= full_count + 2'd1;
                2'b01:   full_count <= full_count - 2'd1;
                default: full_count <= full_count;
            endcase
        end
    end

endmodule

// File: tb/tb_vec_dot_feeder.sv
// Scoreboard bench for vec_dot_feeder: a lane model packs expected vectors on accept,
// and a monitor compares every presented vector against the queue head.
module tb_vec_dot_feeder;

    localparam int FW = 32;
    localparam int VS = 17;
    localparam int VW = FW * VS;
    localparam int CW = $clog2(VS + 1);

    typedef struct {
        logic [VW-1:0] lhs;
        logic [VW-1:0] rhs;
        logic [CW-1:0] cnt;
    } vec_t;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [FW-1:0] in_lhs;
    logic [FW-1:0] in_rhs;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [VW-1:0] out_lhs;
    logic [VW-1:0] out_rhs;
    logic [CW-1:0] out_count;

    vec_t          q[$];
    logic [VW-1:0] m_lhs;
    logic [VW-1:0] m_rhs;
    int            m_lane;
    logic          pop_pending;
    logic [VW-1:0] last_lhs;
    logic [VW-1:0] last_rhs;
    int            errors;
    int            checks;
    int            cyc;

    vec_dot_feeder #(
        .EXP_WIDTH(8),
        .MAN_WIDTH(23),
        .BIAS(-127),
        .VEC_SIZE(VS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_lhs(in_lhs),
        .in_rhs(in_rhs),
        .in_last(in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_lhs(out_lhs),
        .out_rhs(out_rhs),
        .out_count(out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Offers one pair, waits (bounded) for acceptance, then updates the lane model.
    task automatic applyStimulus(input logic [FW-1:0] l, input logic [FW-1:0] r, input logic last);
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_lhs   = l;
        in_rhs   = r;
        in_last  = last;
        for (int w = 0; w < 200; w++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checkOutput("accept_timeout", 0, 1);
            in_valid = 1'b0;
            in_last  = 1'b0;
            return;
        end
        checkOutput("in_ready", in_ready, (q.size() < 2) ? 1 : 0);
        @(posedge clk);
        m_lhs[m_lane*FW +: FW] = l;
        m_rhs[m_lane*FW +: FW] = r;
        m_lane++;
        if (last || m_lane == VS) begin
            vec_t v;
            v.lhs = m_lhs;
            v.rhs = m_rhs;
            v.cnt = CW'(m_lane);
            q.push_back(v);
            m_lhs  = '0;
            m_rhs  = '0;
            m_lane = 0;
            #1;
            checkOutput("latency_out_valid", out_valid, 1);
        end else begin
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic waitEmpty(input string tag);
        for (int w = 0; w < 300; w++) begin
            @(negedge clk);
            if (q.size() == 0) break;
        end
        checkOutput(tag, q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (q.size() == 0) begin
                checkOutput("unexpected_vector", 1, 0);
            end else begin
                checkOutput("vec_lhs", out_lhs, q[0].lhs);
                checkOutput("vec_rhs", out_rhs, q[0].rhs);
                checkOutput("vec_count", VW'(out_count), VW'(q[0].cnt));
                if (out_ready) begin
                    pop_pending = 1'b1;
                    last_lhs    = out_lhs;
                    last_rhs    = out_rhs;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (pop_pending) begin
            if (q.size() > 0) void'(q.pop_front());
            pop_pending = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int            start;
        logic [FW-1:0] sl[6];
        logic [FW-1:0] sr[6];
        shortreal      ref_dot;
        shortreal      dut_dot;

        errors = 0; checks = 0; cyc = 0;
        m_lhs = '0; m_rhs = '0; m_lane = 0; pop_pending = 1'b0;
        last_lhs = '0; last_rhs = '0;
        rst = 1'b1; in_valid = 1'b0; in_lhs = '0; in_rhs = '0; in_last = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        checkOutput("rst_in_ready", in_ready, 1);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_count", VW'(out_count), 0);
        checkOutput("rst_out_lhs", out_lhs, 0);
        checkOutput("rst_out_rhs", out_rhs, 0);

        // Two full vectors back to back with no bubbles.
        start = cyc;
        for (int i = 0; i < 2*VS; i++) applyStimulus($urandom, $urandom, 1'b0);
        checkOutput("no_bubble_cycles", cyc - start, 2*VS);
        waitEmpty("drain_full");

        // Short vector closed by in_last; in_last without in_valid is ignored.
        applyStimulus(32'h3F800000, 32'h40000000, 1'b0);
        applyStimulus($urandom, $urandom, 1'b0);
        in_last = 1'b1;
        repeat (2) @(posedge clk);
        #1 in_last = 1'b0;
        applyStimulus($urandom, $urandom, 1'b0);
        applyStimulus($urandom, $urandom, 1'b0);
        applyStimulus($urandom, $urandom, 1'b1);
        waitEmpty("drain_short");

        // Partial vector then a full one: no stale lanes may leak through.
        for (int i = 0; i < 4; i++) applyStimulus($urandom, $urandom, (i == 3));
        for (int i = 0; i < VS; i++) applyStimulus($urandom, $urandom, 1'b0);
        waitEmpty("drain_partial_full");

        // Backpressure: both buffers fill, input stalls, one handshake frees a slot.
        out_ready = 1'b0;
        for (int i = 0; i < 2*VS; i++) applyStimulus($urandom, $urandom, 1'b0);
        @(negedge clk);
        checkOutput("stall_in_ready", in_ready, 0);
        fork
            applyStimulus($urandom, $urandom, 1'b0);
            begin
                repeat (3) begin
                    @(negedge clk);
                    checkOutput("held_in_ready", in_ready, 0);
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
                @(posedge clk);
                #1 out_ready = 1'b0;
                @(negedge clk);
                checkOutput("ready_after_hs", in_ready, 1);
            end
        join
        for (int i = 0; i < VS-1; i++) applyStimulus($urandom, $urandom, 1'b0);
        @(negedge clk);
        checkOutput("restall_in_ready", in_ready, 0);
        @(posedge clk);
        #1 out_ready = 1'b1;
        waitEmpty("drain_stall");

        // Reset with one full vector pending and a partial one filling.
        out_ready = 1'b0;
        for (int i = 0; i < VS + 9; i++) applyStimulus($urandom, $urandom, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        q.delete();
        m_lhs = '0; m_rhs = '0; m_lane = 0;
        checkOutput("post_rst_out_valid", out_valid, 0);
        checkOutput("post_rst_in_ready", in_ready, 1);
        checkOutput("post_rst_out_lhs", out_lhs, 0);
        out_ready = 1'b1;
        for (int i = 0; i < VS; i++) applyStimulus($urandom, $urandom, 1'b0);
        waitEmpty("drain_after_rst");

        // Special encodings must pass through untouched; normal lanes feed a dot check.
        sl[0] = 32'h7FC00001; sr[0] = 32'h80000000;
        sl[1] = 32'h80000000; sr[1] = 32'h00000001;
        sl[2] = 32'h00000001; sr[2] = 32'h7FC00001;
        sl[3] = 32'h40600000; sr[3] = 32'h3FA00000;
        sl[4] = 32'hBFA00000; sr[4] = 32'h40000000;
        sl[5] = 32'h41200000; sr[5] = 32'hBE800000;
        for (int i = 0; i < 6; i++) applyStimulus(sl[i], sr[i], (i == 5));
        waitEmpty("drain_special");
        ref_dot = 0.0;
        dut_dot = 0.0;
        for (int i = 3; i < 6; i++) begin
            logic [FW-1:0] a;
            logic [FW-1:0] b;
            ref_dot = ref_dot + $bitstoshortreal(sl[i]) * $bitstoshortreal(sr[i]);
            a = last_lhs[i*FW +: FW];
            b = last_rhs[i*FW +: FW];
            dut_dot = dut_dot + $bitstoshortreal(a) * $bitstoshortreal(b);
        end
        checkOutput("dot_result", VW'($shortrealtobits(dut_dot)), VW'($shortrealtobits(ref_dot)));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vec_dot_feeder.md
VEC_DOT_FEEDER -- requirements
Module: vec_dot_feeder

Interface
REQ-001 SHALL have parameter EXP_WIDTH, default 8, exponent field width.
REQ-002 SHALL have parameter MAN_WIDTH, default 23, mantissa field width.
REQ-003 SHALL have parameter BIAS, default -127, exponent bias; propagated only, not used.
REQ-004 SHALL have parameter VEC_SIZE, default 17, lanes per output vector; legal range 2 or more.
REQ-005 SHALL define FLOAT_WIDTH = 1+EXP_WIDTH+MAN_WIDTH, VEC_WIDTH = VEC_SIZE*FLOAT_WIDTH, CW = clog2(VEC_SIZE+1).
REQ-006 SHALL have one clock and a synchronous, active-high reset; all state updates on the rising edge of clk.
REQ-007 Port list:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  element pair offered.
- in_ready  out  1  element pair accepted when in_valid&in_ready.
- in_lhs  in  FLOAT_WIDTH  lhs element bits.
- in_rhs  in  FLOAT_WIDTH  rhs element bits.
- in_last  in  1  element closes the current vector early.
- out_valid  out  1  vector pair available.
- out_ready  in  1  consumer takes vector when out_valid&out_ready.
- out_lhs  out  VEC_WIDTH  packed lhs vector for vec_dot.
- out_rhs  out  VEC_WIDTH  packed rhs vector for vec_dot.
- out_count  out  CW  number of real (non-padded) lanes, 1..VEC_SIZE.

Function
REQ-008 Lane i SHALL occupy bits [i*FLOAT_WIDTH +: FLOAT_WIDTH] of out_lhs/out_rhs; the first accepted element of a vector goes to lane 0.
REQ-009 SHALL hold two vector buffers (ping-pong), each with lhs, rhs, count; a write-select, a read-select and a full-buffer count (0..2).
REQ-010 Element bits SHALL be stored unmodified (no rounding, NaN/denormal passthrough).
REQ-011 in_ready SHALL equal (full-buffer count < 2), combinationally from registered state only; no combinational path from out_ready to in_ready.
REQ-012 On accept, element SHALL be written to lane = lane counter of write buffer; lane counter increments.
REQ-013 Buffer SHALL complete when accepted element lands in lane VEC_SIZE-1 or in_last=1; on completion, count = lane+1, lane counter returns to 0, write-select toggles, full count increments.
REQ-014 On completion by in_last with fewer than VEC_SIZE lanes, unfilled lanes SHALL read as all-zero (+0.0) in both vectors.
REQ-015 Filling buffer SHALL be cleared to zero when it becomes the write buffer, so no stale lanes from a prior vector appear.
REQ-016 out_valid SHALL equal (full count > 0); out_lhs/out_rhs/out_count SHALL present the read-select buffer and hold stable while out_valid&~out_ready.
REQ-017 On output handshake, read-select SHALL toggle and full count decrement.
REQ-018 Latency: out_valid SHALL assert the cycle after the completing element's accept edge (one cycle).
REQ-019 Completion and output handshake in the same cycle SHALL leave full count unchanged, both selects toggle.
REQ-020 Throughput: with out_ready held 1, SHALL accept one element per cycle indefinitely with no bubbles.
REQ-021 With full count 2, in_ready=0; input SHALL stall with no element lost or overwritten; in_ready returns 1 the cycle after an output handshake.
REQ-022 in_valid with in_ready=0 SHALL have no effect; in_last SHALL be ignored unless accepted.

Reset
REQ-023 While rst=1 at a clock edge: full count 0, lane counter 0, both selects 0, all buffer contents and counts 0; in_ready=1, out_valid=0, out_lhs=0, out_rhs=0, out_count=0 from the following cycle.
REQ-024 Reset mid-vector or with full buffers SHALL discard all partial and pending vectors; no vector emitted after reset until new input completes one.

Verification
REQ-025 Stream 2*VEC_SIZE random float pairs, out_ready=1 -> two vectors, each one cycle after lanes 16 and 33 accepted, lanes in order, out_count=17, in_ready never drops.
REQ-026 Send 5 pairs with in_last on 5th -> out_count=5, lanes 0-4 match inputs, lanes 5-16 = 0x00000000 in both vectors.
REQ-027 out_ready=0, stream 3*VEC_SIZE pairs -> in_ready drops after the 34th accept; the 35th is held; raising out_ready for one cycle -> vector 1 emitted, in_ready=1 next cycle, vector 3 later intact.
REQ-028 Partial vector (in_last at lane 3) followed by a full vector -> second vector lanes 4-16 carry new data, no stale values from the first.
REQ-029 Assert rst after 9 pairs accepted and one full vector pending -> out_valid=0 next cycle, in_ready=1, next 17 pairs produce one vector with correct lanes.
REQ-030 Feed NaN (0x7FC00001), -0.0 (0x80000000), denormal (0x00000001) -> identical bits in output lanes; check vec_dot result against shortreal reference.
